apuf_eval_ctrl: RTL and testbench
=================================

APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 SHALL have parameter nStage, default 16: challenge width, equal to the switch-chain stage count.
REQ-002 SHALL have parameter SETTLE_C, default 4: cycles that chal_o is held stable before trig rises (>=1).
REQ-003 SHALL have parameter RESP_C, default 8: cycles trig stays high before arb_in is sampled (>=1).
REQ-004 SHALL have parameter RELAX_C, default 4: cycles trig stays low after each sample (>=1).
REQ-005 SHALL have parameter NREP, default 5: evaluations per request; must be odd and >=1.
REQ-006 SHALL have port: clk  input  1  sole clock; all logic is on its rising edge.
REQ-007 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port: start  input  1  evaluation request, sampled only in IDLE.
REQ-009 SHALL have port: chal  input  nStage  challenge, captured when start is accepted.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port: chal_o  output  nStage  registered challenge driving the switch-chain select bits.
REQ-012 SHALL have port: trig  output  1  registered trigger driving both chain inputs (top and bottom).
REQ-013 SHALL have port: arb_in  input  1  arbiter latch output at the chain end.
REQ-014 SHALL have port: resp  output  1  final response, held until the next resp_valid.
REQ-015 SHALL have port: ones  output  $clog2(NREP+1)  count of 1-samples in the last request.
REQ-016 SHALL have port: resp_valid  output  1  one-cycle pulse marking resp/ones as updated.

Function
REQ-017 SHALL use states IDLE, LOAD, FIRE, RELAX and DONE.
REQ-018 SHALL, when start=1 in IDLE at cycle T, load chal into chal_o, clear the sample counter and ones accumulator, and enter LOAD at T+1.
REQ-019 SHALL stay exactly SETTLE_C cycles in LOAD with trig=0, then enter FIRE.
REQ-020 SHALL hold trig=1 for exactly RESP_C cycles in FIRE, sample arb_in on the last FIRE cycle, add it to ones, and enter RELAX.
REQ-021 SHALL hold trig=0 for exactly RELAX_C cycles in RELAX, then enter FIRE again if fewer than NREP samples have been taken, else enter DONE.
REQ-022 SHALL, in DONE (one cycle), set resp = (ones > NREP/2), pulse resp_valid=1, and return to IDLE.
REQ-023 SHALL place the resp_valid pulse at cycle T+1+SETTLE_C+NREP*(RESP_C+RELAX_C).
REQ-024 SHALL keep chal_o constant from LOAD through DONE, and hold it in IDLE until the next accepted start.
REQ-025 SHALL ignore start while busy=1; no queuing.
REQ-026 SHALL accept a start asserted in the same cycle as DONE only on the following IDLE cycle.
REQ-027 SHALL size all counters so that the maximum parameter values cause no wrap-around.

Reset
REQ-028 SHALL, on rst=1 (asynchronous, mid-operation included), force state=IDLE, trig=0, chal_o=0, resp=0, ones=0, resp_valid=0, busy=0 and clear all counters.
REQ-029 SHALL produce no resp_valid for a request aborted by reset.

Configuration
REQ-030 SHALL, with macro APUF_MAJORITY_VOTE_EN defined, perform NREP evaluations and a majority vote.
REQ-031 SHALL, without APUF_MAJORITY_VOTE_EN, treat NREP as 1, set resp = sampled arb_in and set ones = {0..,resp}; the resp_valid pulse then falls at T+1+SETTLE_C+RESP_C+RELAX_C.

Structure
REQ-032 SHALL place the state enum and a counter-width helper function in package apuf_ctrl_pkg.
REQ-033 SHALL implement the LOAD/FIRE/RELAX duration timer as sub-module apuf_timer (loadable down-counter with a zero flag).

Verification
REQ-034 SHALL cover: defaults, macro on, chal=16'hA5C3, arb_in=1 constant -> chal_o=16'hA5C3 at cycle 1; trig high in cycles 5-12, 17-24, 29-36, 41-48, 53-60; resp_valid at cycle 65; resp=1, ones=5.
REQ-035 SHALL cover: arb_in pattern 1,0,1,0,0 across the five samples -> ones=2, resp=0.
REQ-036 SHALL cover: start held high during busy, with chal changed at cycle 20 -> chal_o unchanged; exactly one resp_valid.
REQ-037 SHALL cover: rst pulsed at cycle 30 -> trig=0 and busy=0 immediately; no resp_valid; a new start at cycle 40 is accepted normally.
REQ-038 SHALL cover: macro off, arb_in=1 -> a single trig pulse in cycles 5-12; resp_valid at cycle 17; resp=1, ones=1.

Source files
------------

// File: rtl/apuf_ctrl_pkg.sv
// Shared types and helpers for the arbiter-PUF evaluation controller.
package apuf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    RELAX,
    DONE
  } state_e;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/apuf_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags the final cycle of a phase.
module apuf_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: settle challenge, fire trigger, sample arbiter, repeat.
// Macro APUF_MAJORITY_VOTE_EN enables NREP evaluations with majority vote; otherwise one evaluation.
module apuf_eval_ctrl
  import apuf_ctrl_pkg::*;
#(
  parameter int unsigned nStage   = 16,
  parameter int unsigned SETTLE_C = 4,
  parameter int unsigned RESP_C   = 8,
  parameter int unsigned RELAX_C  = 4,
  parameter int unsigned NREP     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [nStage-1:0]         chal,
  output logic                      busy,
  output logic [nStage-1:0]         chal_o,
  output logic                      trig,
  input  logic                      arb_in,
  output logic                      resp,
  output logic [$clog2(NREP+1)-1:0] ones,
  output logic                      resp_valid
);

`ifdef APUF_MAJORITY_VOTE_EN
  localparam int unsigned NREP_E = NREP;
`else
  localparam int unsigned NREP_E = 1;
`endif

  localparam int unsigned OW   = $clog2(NREP + 1);
  localparam int unsigned SW   = cnt_width(NREP_E);
  localparam int unsigned TMAX = (SETTLE_C > RESP_C)
                                 ? ((SETTLE_C > RELAX_C) ? SETTLE_C : RELAX_C)
                                 : ((RESP_C > RELAX_C) ? RESP_C : RELAX_C);
  localparam int unsigned TW   = cnt_width(TMAX);

  // Timer holds duration-1 so that zero marks the last cycle of each phase.
  localparam logic [TW-1:0] SETTLE_V = TW'(SETTLE_C - 1);
  localparam logic [TW-1:0] RESP_V   = TW'(RESP_C - 1);
  localparam logic [TW-1:0] RELAX_V  = TW'(RELAX_C - 1);
  localparam logic [SW-1:0] NREP_V   = SW'(NREP_E);
  localparam logic [OW-1:0] HALF_V   = OW'(NREP_E / 2);

  state_e            state_q, state_d;
  logic [nStage-1:0] chal_q, chal_d;
  logic [SW-1:0]     smp_q, smp_d;
  logic [OW-1:0]     acc_q, acc_d;
  logic [OW-1:0]     ones_q, ones_d;
  logic              resp_q, resp_d;
  logic              trig_q, valid_q;
  logic              t_load;
  logic [TW-1:0]     t_val;
  logic              t_zero;

  apuf_timer #(
    .W(TW)
  ) u_timer (
    .clk_i (clk),
    .rst_i (rst),
    .load_i(t_load),
    .val_i (t_val),
    .zero_o(t_zero)
  );

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    smp_d   = smp_q;
    acc_d   = acc_q;
    ones_d  = ones_q;
    resp_d  = resp_q;
    t_load  = 1'b0;
    t_val   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          chal_d  = chal;
          smp_d   = '0;
          acc_d   = '0;
          t_load  = 1'b1;
          t_val   = SETTLE_V;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (t_zero) begin
          t_load  = 1'b1;
          t_val   = RESP_V;
          state_d = FIRE;
        end
      end
      FIRE: begin
        if (t_zero) begin
          acc_d   = acc_q + OW'(arb_in);
          smp_d   = smp_q + 1'b1;
          t_load  = 1'b1;
          t_val   = RELAX_V;
          state_d = RELAX;
        end
      end
      RELAX: begin
        if (t_zero) begin
          if (smp_q < NREP_V) begin
            t_load  = 1'b1;
            t_val   = RESP_V;
            state_d = FIRE;
          end else begin
            resp_d  = (acc_q > HALF_V);
            ones_d  = acc_q;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // trig and resp_valid are registered from the next state so they align with FIRE/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      chal_q  <= '0;
      smp_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      resp_q  <= 1'b0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      resp_q  <= resp_d;
      trig_q  <= (state_d == FIRE);
      valid_q <= (state_d == DONE);
    end
  end

  assign busy       = (state_q != IDLE);
  assign chal_o     = chal_q;
  assign trig       = trig_q;
  assign resp       = resp_q;
  assign ones       = ones_q;
  assign resp_valid = valid_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl; expectations follow APUF_MAJORITY_VOTE_EN when defined.
module tb_apuf_eval_ctrl;

  localparam int S   = 4;
  localparam int R   = 8;
  localparam int X   = 4;
`ifdef APUF_MAJORITY_VOTE_EN
  localparam int NE  = 5;
`else
  localparam int NE  = 1;
`endif
  localparam int PER  = R + X;
  localparam int EXPV = 1 + S + NE * PER;

  logic        clk = 1'b0;
  logic        rst, start, arb_in;
  logic [15:0] chal;
  logic        busy, trig, resp, resp_valid;
  logic [15:0] chal_o;
  logic [2:0]  ones;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] chal;
    logic [4:0]  pat;      // bit k = arbiter value for sample k
    logic [2:0]  ones_mv;
    logic        resp_mv;
    logic [2:0]  ones_one;
    logic        resp_one;
  } vec_t;

  vec_t vt[6];

  apuf_eval_ctrl #(
    .nStage  (16),
    .SETTLE_C(S),
    .RESP_C  (R),
    .RELAX_C (X),
    .NREP    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .chal      (chal),
    .busy      (busy),
    .chal_o    (chal_o),
    .trig      (trig),
    .arb_in    (arb_in),
    .resp      (resp),
    .ones      (ones),
    .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic exp_trig(input int c);
    int x;
    x = c - 1 - S;
    return (x >= 0) && (x < NE * PER) && ((x % PER) < R);
  endfunction

  // Called at a negedge with the DUT idle; that negedge is cycle 0.
  task automatic run_req(input logic [15:0] c_val, input logic [4:0] pat, input int hold_to,
                         input int chg_at, input logic [15:0] chg_val,
                         input logic [2:0] e_ones, input logic e_resp, input string tag);
    int vcnt, vcyc, tbad, cbad, bbad, x;
    logic       r_v;
    logic [2:0] o_v;
    vcnt = 0; vcyc = -1; tbad = 0; cbad = 0; bbad = 0;
    r_v = 1'bx; o_v = 'x;
    chal  = c_val;
    start = 1'b1;
    for (int c = 1; c <= EXPV + 4; c++) begin
      @(negedge clk);
      if (c >= hold_to) start = 1'b0;
      if (c == chg_at) chal = chg_val;
      x = c - 1 - S;
      if (x >= 0 && x < NE * PER) arb_in = pat[x / PER];
      if (trig !== exp_trig(c)) tbad++;
      if (chal_o !== c_val) cbad++;
      if (busy !== (c <= EXPV)) bbad++;
      if (resp_valid === 1'b1) begin
        vcnt++;
        vcyc = c;
        r_v  = resp;
        o_v  = ones;
      end
    end
    chk({tag, ".valid_count"}, vcnt, 1);
    chk({tag, ".valid_cycle"}, vcyc, EXPV);
    chk({tag, ".resp"}, r_v, e_resp);
    chk({tag, ".ones"}, o_v, e_ones);
    chk({tag, ".trig_bad_cycles"}, tbad, 0);
    chk({tag, ".chal_o_bad_cycles"}, cbad, 0);
    chk({tag, ".busy_bad_cycles"}, bbad, 0);
    chk({tag, ".resp_held"}, resp, e_resp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcnt, bbad;
    vt[0] = '{16'hA5C3, 5'b11111, 3'd5, 1'b1, 3'd1, 1'b1};
    vt[1] = '{16'h1234, 5'b00101, 3'd2, 1'b0, 3'd1, 1'b1};
    vt[2] = '{16'hFFFF, 5'b00000, 3'd0, 1'b0, 3'd0, 1'b0};
    vt[3] = '{16'h0000, 5'b10110, 3'd3, 1'b1, 3'd0, 1'b0};
    vt[4] = '{16'h8001, 5'b11011, 3'd4, 1'b1, 3'd1, 1'b1};
    vt[5] = '{16'h5A5A, 5'b10000, 3'd1, 1'b0, 3'd0, 1'b0};

    rst = 1'b1; start = 1'b0; arb_in = 1'b0; chal = '0;
    repeat (2) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.trig", trig, 0);
    chk("reset.chal_o", chal_o, 0);
    chk("reset.resp", resp, 0);
    chk("reset.ones", ones, 0);
    chk("reset.resp_valid", resp_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_req(vt[i].chal, vt[i].pat, 1, 0, 16'h0000,
              (NE > 1) ? vt[i].ones_mv : vt[i].ones_one,
              (NE > 1) ? vt[i].resp_mv : vt[i].resp_one,
              $sformatf("vec%0d", i));
    end

    // start held through the request with chal changing mid-flight.
    run_req(16'h3C3C, 5'b11111, EXPV - 1, (NE > 1) ? 20 : 10, 16'hDEAD,
            (NE > 1) ? 3'd5 : 3'd1, 1'b1, "hold");

    // start raised only in the DONE cycle is ignored; held one more cycle it is accepted.
    chal = 16'h0F0F; start = 1'b1; arb_in = 1'b1;
    for (int c = 1; c <= EXPV + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == EXPV) begin
        chk("done_start.valid_at_done", resp_valid, 1);
        chal  = 16'hF0F0;
        start = 1'b1;
      end
      if (c == EXPV + 1) chk("done_start.busy_after_done", busy, 0);
      if (c == EXPV + 2) begin
        chk("done_start.busy_accepted", busy, 1);
        chk("done_start.chal_o", chal_o, 16'hF0F0);
        start = 1'b0;
      end
    end
    vcnt = 0;
    for (int c = 0; c < EXPV + 4; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) vcnt++;
    end
    chk("done_start.second_valid", vcnt, 1);
    chk("done_start.ones", ones, (NE > 1) ? 5 : 1);

    // Reset in the middle of a FIRE phase aborts the request.
    chal = 16'hBEEF; start = 1'b1; arb_in = 1'b1;
    for (int c = 1; c <= ((NE > 1) ? 30 : 9); c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("abort.trig_before", trig, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort.trig", trig, 0);
    chk("abort.busy", busy, 0);
    chk("abort.chal_o", chal_o, 0);
    chk("abort.ones", ones, 0);
    chk("abort.resp", resp, 0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0; bbad = 0;
    for (int c = ((NE > 1) ? 31 : 10); c < 40 + EXPV; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) vcnt++;
      if (busy !== 1'b0) bbad++;
    end
    chk("abort.no_valid", vcnt, 0);
    chk("abort.stays_idle", bbad, 0);
    run_req(16'h7777, 5'b11111, 1, 0, 16'h0000, (NE > 1) ? 3'd5 : 3'd1, 1'b1, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
